fpu_issue_ctrl: RTL



---
 rtl/fpu_issue_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fpu_issue_ctrl.sv
// Issue/response controller for the combinational FPU: holds the operands for an op-dependent latency, then returns the result.
// Optional sticky exception flags are enabled with the FPU_STICKY_FLAGS_EN macro.
module fpu_issue_ctrl #(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_tag,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_op,
    input  logic [31:0] fpu_result,
    input  logic        fpu_overflow,
    input  logic        fpu_underflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_tag,
    output logic        rsp_overflow,
    output logic        rsp_underflow,
    output logic        busy,
    input  logic        flags_clr,
    output logic        sticky_overflow,
    output logic        sticky_underflow
);

    // A latency of zero still needs one EXEC cycle to sample the FPU.
    localparam int ADD_EFF = (ADD_LAT < 1) ? 1 : ADD_LAT;
    localparam int MUL_EFF = (MUL_LAT < 1) ? 1 : MUL_LAT;
    localparam int DIV_EFF = (DIV_LAT < 1) ? 1 : DIV_LAT;
    localparam int MAX_AM  = (ADD_EFF > MUL_EFF) ? ADD_EFF : MUL_EFF;
    localparam int MAX_LAT = (MAX_AM > DIV_EFF) ? MAX_AM : DIV_EFF;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             capture;

    function automatic logic [CNT_W-1:0] lat_minus_one(input logic [1:0] op);
        case (op)
            2'b10:   return CNT_W'(MUL_EFF - 1);
            2'b11:   return CNT_W'(DIV_EFF - 1);
            default: return CNT_W'(ADD_EFF - 1);
        endcase
    endfunction

    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign capture   = (state == EXEC) && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            fpu_a         <= '0;
            fpu_b         <= '0;
            fpu_op        <= '0;
            rsp_result    <= '0;
            rsp_tag       <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        fpu_a   <= req_a;
                        fpu_b   <= req_b;
                        fpu_op  <= req_op;
                        rsp_tag <= req_tag;
                        count   <= lat_minus_one(req_op);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (count != '0) begin
                        count <= count - CNT_W'(1);
                    end else begin
                        rsp_result    <= fpu_result;
                        rsp_overflow  <= fpu_overflow;
                        rsp_underflow <= fpu_underflow;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FPU_STICKY_FLAGS_EN
    // A clear coinciding with a capture only wipes the history, not the new flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_overflow  <= 1'b0;
            sticky_underflow <= 1'b0;
        end else if (capture) begin
            sticky_overflow  <= (sticky_overflow  & ~flags_clr) | fpu_overflow;
            sticky_underflow <= (sticky_underflow & ~flags_clr) | fpu_underflow;
        end else if (flags_clr) begin
            sticky_overflow  <= 1'b0;
            sticky_underflow <= 1'b0;
        end
    end
`else
    logic unused_sticky_inputs;
    assign unused_sticky_inputs = flags_clr | capture;
    assign sticky_overflow      = 1'b0;
    assign sticky_underflow     = 1'b0;
`endif

endmodule
